// File: rtl/fxp_matvec_mul.sv
// Fixed-point N x N matrix times N-vector, one MAC per cycle, each result normalised to its own Q format.
// Latency: start -> row 0 out_valid after N+2 cycles; each further row N+2 cycles after the previous accept.
// Backpressure: a result is held stable on out_valid until out_ready; nothing is computed while it waits.
//
// Ports:
//   src_clk, rst (async, active-high)      clock and reset
//   we, addr, data_wr                       operand write port (IDLE only); matrix row-major at 0..N*N-1, vector at N*N..
//   start / busy / done                     job control: start pulse, busy until done, one-cycle done pulse
//   out_valid, out_ready, out_data, out_idx result stream with row index
//   QI, QF, ovf                             Q format of out_data (integer bits excl. sign, fraction bits), saturation flag
// Optional macro FXP_ROUND_EN: round-half-up during normalisation instead of truncation.
module fxp_matvec_mul #(
  parameter int WORD_SIZE = 16,
  parameter int N         = 8,
  parameter int FRAC_IN   = 8,
  parameter int ADDR_W    = 7,
  parameter int Q_W       = 5
) (
  input  logic                   src_clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WORD_SIZE-1:0]   data_wr,
  input  logic                   start,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic [Q_W-1:0]         QI,
  output logic [Q_W-1:0]         QF,
  output logic                   ovf,
  output logic                   done
);

  localparam int IDX_W  = $clog2(N);
  localparam int DEPTH  = N * N + N;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int ACC_W  = 2 * WORD_SIZE + $clog2(N);
  // One extra bit so the rounding increment can never wrap.
  localparam int EXT_W  = ACC_W + 1;
  localparam int S_MIN  = (2 * FRAC_IN - WORD_SIZE + 1 > 0) ? (2 * FRAC_IN - WORD_SIZE + 1) : 0;
  // At this shift the accumulator always fits in WORD_SIZE bits.
  localparam int S_MAX  = ACC_W - WORD_SIZE;

  localparam logic signed [EXT_W-1:0] MAX_W = {{(EXT_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_W = {{(EXT_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_NORM, S_OUT, S_DONE} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             row_cnt;
  logic [IDX_W-1:0]             col_cnt;
  logic signed [ACC_W-1:0]      acc;
  logic signed [WORD_SIZE-1:0]  mem [0:DEPTH-1];

  // Operand memory: no reset, writes only while idle and in range.
  always_ff @(posedge src_clk) begin
    if (we && state == S_IDLE && int'(addr) < DEPTH)
      mem[MEM_AW'(addr)] <= data_wr;
  end

  logic signed [WORD_SIZE-1:0]   a_op, v_op;
  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]       prod_ext;

  assign a_op     = mem[MEM_AW'(int'(row_cnt) * N + int'(col_cnt))];
  assign v_op     = mem[MEM_AW'(N * N + int'(col_cnt))];
  assign prod     = a_op * v_op;
  assign prod_ext = {{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};

  function automatic logic fits(input logic signed [EXT_W-1:0] v, input int sh);
    logic signed [EXT_W-1:0] t;
    t = v >>> sh;
    return (t <= MAX_W) && (t >= MIN_W);
  endfunction

  // Normalisation: smallest shift from S_MIN that brings acc into range.
  logic signed [EXT_W-1:0]   acc_ext, rnd;
  int                        shift;
  logic                      found;
  logic [WORD_SIZE-1:0]      norm_data;
  logic [Q_W-1:0]            norm_qf;
  logic                      norm_ovf;

  assign acc_ext = {acc[ACC_W-1], acc};

  always_comb begin
    shift = S_MAX;
    found = 1'b0;
    for (int k = S_MIN; k <= S_MAX; k++) begin
      if (!found && fits(acc_ext, k)) begin
        shift = k;
        found = 1'b1;
      end
    end
    rnd = acc_ext;
`ifdef FXP_ROUND_EN
    if (shift > 0) begin
      rnd = acc_ext + (EXT_W'(1) <<< (shift - 1));
      // Rounding carried past the top: renormalise one step further.
      if (!fits(rnd, shift)) begin
        shift = shift + 1;
        rnd   = acc_ext + (EXT_W'(1) <<< (shift - 1));
      end
    end
`endif
    if (shift <= 2 * FRAC_IN) begin
      norm_data = WORD_SIZE'(rnd >>> shift);
      norm_qf   = Q_W'(2 * FRAC_IN - shift);
      norm_ovf  = 1'b0;
    end else begin
      norm_data = acc[ACC_W-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
      norm_qf   = '0;
      norm_ovf  = 1'b1;
    end
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      col_cnt   <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      QI        <= '0;
      QF        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_MAC;
            busy    <= 1'b1;
            row_cnt <= '0;
            col_cnt <= '0;
            acc     <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (col_cnt == IDX_W'(N - 1)) begin
            col_cnt <= '0;
            state   <= S_NORM;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        S_NORM: begin
          out_data  <= norm_data;
          out_idx   <= row_cnt;
          QF        <= norm_qf;
          QI        <= Q_W'(WORD_SIZE - 1) - norm_qf;
          ovf       <= norm_ovf;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row_cnt == IDX_W'(N - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
              acc     <= '0;
              state   <= S_MAC;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_matvec_mul.sv
// Self-checking bench for fxp_matvec_mul: directed and random matrices against an arithmetic reference model.
// Covers reset values, latency, Q format/saturation, backpressure hold, ignored writes/starts while busy, reset abort.
// Prints one TB_RESULT summary line.
module tb_fxp_matvec_mul;

  localparam int WS    = 16;
  localparam int N     = 8;
  localparam int FI    = 8;
  localparam int AW    = 7;
  localparam int QW    = 5;
  localparam int DEPTH = N * N + N;
  localparam int S_MIN = (2 * FI - WS + 1 > 0) ? (2 * FI - WS + 1) : 0;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic                  src_clk = 1'b0;
  logic                  rst;
  logic                  we;
  logic [AW-1:0]         addr;
  logic [WS-1:0]         data_wr;
  logic                  start;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [WS-1:0]         out_data;
  logic [$clog2(N)-1:0]  out_idx;
  logic [QW-1:0]         QI;
  logic [QW-1:0]         QF;
  logic                  ovf;
  logic                  done;

  int checks   = 0;
  int failures = 0;
  int mem_m [0:DEPTH-1];

  fxp_matvec_mul #(.WORD_SIZE(WS), .N(N), .FRAC_IN(FI), .ADDR_W(AW), .Q_W(QW)) dut (
    .src_clk(src_clk), .rst(rst), .we(we), .addr(addr), .data_wr(data_wr),
    .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .QI(QI), .QF(QF), .ovf(ovf), .done(done)
  );

  always #5 src_clk = ~src_clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd_word();
    int mag;
    mag = $urandom_range(0, 32767) >> $urandom_range(0, 14);
    if ($urandom_range(0, 1) == 1) mag = -mag;
    return mag;
  endfunction

  // Reference: exact dot product, then the smallest legal shift that fits a signed 16-bit word.
  function automatic void model_row(input int r, output int d, output int qi, output int qf, output int o);
    longint acc, res, one;
    int s;
    acc = 0;
    one = 1;
    for (int j = 0; j < N; j++)
      acc += longint'(mem_m[r*N + j]) * longint'(mem_m[N*N + j]);
    s = S_MIN;
    while ((acc >>> s) > MAXV || (acc >>> s) < MINV) s++;
    res = acc >>> s;
`ifdef FXP_ROUND_EN
    if (s > 0) begin
      res = (acc + (one << (s - 1))) >>> s;
      if (res > MAXV) begin
        s++;
        res = (acc + (one << (s - 1))) >>> s;
      end
    end
`endif
    if (s <= 2 * FI) begin
      d  = int'(res) & 32'hFFFF;
      qf = 2 * FI - s;
      o  = 0;
    end else begin
      d  = (acc < 0) ? 32'h8000 : 32'h7FFF;
      qf = 0;
      o  = 1;
    end
    qi = WS - 1 - qf;
  endfunction

  task automatic load_all();
    for (int a = 0; a < DEPTH; a++) begin
      we      = 1'b1;
      addr    = AW'(a);
      data_wr = WS'(mem_m[a]);
      @(negedge src_clk);
    end
    we = 1'b0;
  endtask

  task automatic run_job(input string name, input int stall_row, input int stall_len,
                         input bit inject_busy, input int sim_addr, input int sim_data);
    int exp_d [N];
    int exp_qi[N];
    int exp_qf[N];
    int exp_o [N];
    int lat;
    if (sim_addr >= 0) mem_m[sim_addr] = sx(16'(sim_data));
    for (int r = 0; r < N; r++) model_row(r, exp_d[r], exp_qi[r], exp_qf[r], exp_o[r]);
    start = 1'b1;
    if (sim_addr >= 0) begin
      we      = 1'b1;
      addr    = AW'(sim_addr);
      data_wr = WS'(sim_data);
    end
    @(negedge src_clk);
    start = 1'b0;
    we    = 1'b0;
    lat   = 1;
    for (int r = 0; r < N; r++) begin
      while (!out_valid && lat < 4 * N + 20) begin
        if (inject_busy && r == 0 && lat == 2) begin
          we      = 1'b1;
          addr    = AW'(5);
          data_wr = WS'($urandom);
          start   = 1'b1;
        end else begin
          we    = 1'b0;
          start = 1'b0;
        end
        @(negedge src_clk);
        lat++;
      end
      we    = 1'b0;
      start = 1'b0;
      check($sformatf("%s_lat_r%0d", name, r), lat, N + 2);
      check($sformatf("%s_idx_r%0d", name, r), out_idx, r);
      check($sformatf("%s_data_r%0d", name, r), out_data, exp_d[r]);
      check($sformatf("%s_qi_r%0d", name, r), QI, exp_qi[r]);
      check($sformatf("%s_qf_r%0d", name, r), QF, exp_qf[r]);
      check($sformatf("%s_ovf_r%0d", name, r), ovf, exp_o[r]);
      check($sformatf("%s_busy_r%0d", name, r), busy, 1);
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge src_clk);
          check($sformatf("%s_hold_vld%0d", name, k), out_valid, 1);
          check($sformatf("%s_hold_dat%0d", name, k), out_data, exp_d[r]);
          check($sformatf("%s_hold_idx%0d", name, k), out_idx, r);
          check($sformatf("%s_hold_q%0d", name, k), {QI, QF}, {exp_qi[r][QW-1:0], exp_qf[r][QW-1:0]});
        end
        out_ready = 1'b1;
      end
      @(negedge src_clk);
      lat = 1;
      check($sformatf("%s_vld_clr_r%0d", name, r), out_valid, 0);
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy_end"}, busy, 0);
    @(negedge src_clk);
    check({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst       = 1'b1;
    we        = 1'b0;
    addr      = '0;
    data_wr   = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge src_clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_qiqf", {QI, QF}, 0);
    rst = 1'b0;
    @(negedge src_clk);

    // Identity in Q7.8, vector k*1.0.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) mem_m[i*N + j] = (i == j) ? 256 : 0;
      mem_m[N*N + i] = (i + 1) * 256;
    end
    load_all();
    run_job("ident", -1, 0, 1'b0, -1, 0);

    // Full-scale positive everywhere: saturates.
    for (int a = 0; a < DEPTH; a++) mem_m[a] = 32767;
    load_all();
    run_job("sat", -1, 0, 1'b0, -1, 0);

    // -1.0 diagonal, -0.5 vector.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) mem_m[i*N + j] = (i == j) ? sx(16'hFF00) : 0;
      mem_m[N*N + i] = sx(16'hFF80);
    end
    load_all();
    run_job("neg", -1, 0, 1'b0, -1, 0);

    for (int a = 0; a < N * N; a++) mem_m[a] = 0;
    load_all();
    run_job("zero", -1, 0, 1'b0, -1, 0);

    // Random operands: backpressure + ignored busy write/start, then write coincident with start.
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < DEPTH; a++) mem_m[a] = rnd_word();
      load_all();
      case (t)
        0:       run_job("rnd0", 3, 5, 1'b1, -1, 0);
        1:       run_job("rnd1", -1, 0, 1'b0, N * N + 2, rnd_word());
        default: run_job($sformatf("rnd%0d", t), t, 2, 1'b0, -1, 0);
      endcase
    end

    // Abort during row 2 MAC, then rerun from retained memory.
    start = 1'b1;
    @(negedge src_clk);
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4 * N + 20 && !out_valid; c++) @(negedge src_clk);
      @(negedge src_clk);
    end
    repeat (3) @(negedge src_clk);
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    @(negedge src_clk);
    rst = 1'b0;
    @(negedge src_clk);
    check("abort_no_done", done, 0);
    run_job("post_rst", -1, 0, 1'b0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
